hwpf_issue_ctrl: RTL and testbench

HWPF_ISSUE_CTRL -- requirements
Module: hwpf_issue_ctrl

---
 rtl/drac_pkg.sv | 15 +
 rtl/hwpf_credit_cnt.sv | 34 +++
 rtl/hwpf_issue_ctrl.sv | 114 +++++++++++
 tb/tb_hwpf_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared definitions for the data-cache request path: prefetch issue FSM
// states and default line size / prefetch credit constants.
package drac_pkg;

    localparam int unsigned HWPF_LINE_BYTES      = 64;
    localparam int unsigned HWPF_MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        HWPF_IDLE,
        HWPF_POP,
        HWPF_CAPTURE,
        HWPF_ISSUE
    } hwpf_state_e;

endpackage

// File: rtl/hwpf_credit_cnt.sv
// Prefetch credit tracker: counts prefetches in flight, never over- or
// underflows, and flags when no further prefetch may be launched.
module hwpf_credit_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic inc_eff;
    logic dec_eff;

    assign full    = (count == CNT_W'(MAX_OUTSTANDING));
    assign inc_eff = inc && !full;
    assign dec_eff = dec && (count != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (inc_eff && !dec_eff) begin
            count <= count + CNT_W'(1);
        end else if (dec_eff && !inc_eff) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/hwpf_issue_ctrl.sv
// Hardware prefetch issue controller: pops the prefetch FIFO during demand
// lulls and slips line-aligned prefetches onto the dcache port behind demand.
module hwpf_issue_ctrl
    import drac_pkg::*;
#(
    parameter int unsigned ADDR_W          = 40,
    parameter int unsigned LINE_BYTES      = HWPF_LINE_BYTES,
    parameter int unsigned MAX_OUTSTANDING = HWPF_MAX_OUTSTANDING,
    parameter int unsigned IDLE_CYCLES     = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 enable_i,
    input  logic                                 flush_i,
    input  logic                                 dmd_valid_i,
    input  logic [ADDR_W-1:0]                    dmd_addr_i,
    output logic                                 dmd_ready_o,
    output logic                                 pf_read_o,
    input  logic                                 pf_valid_i,
    input  logic [ADDR_W-1:0]                    pf_addr_i,
    output logic                                 mem_valid_o,
    output logic [ADDR_W-1:0]                    mem_addr_o,
    output logic                                 mem_is_pf_o,
    input  logic                                 mem_ready_i,
    input  logic                                 pf_rsp_valid_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

    localparam int unsigned      CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned      IDLE_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    hwpf_state_e       state_q, state_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              pf_present;
    logic              pf_grant;
    logic              cred_full;

    // A flush cycle must never launch the held prefetch, so it hides it.
    assign pf_present  = (state_q == HWPF_ISSUE) && !dmd_valid_i && !flush_i;
    assign pf_grant    = pf_present && mem_ready_i;

    assign pf_read_o   = (state_q == HWPF_POP);
    assign dmd_ready_o = dmd_valid_i && mem_ready_i;
    assign mem_valid_o = dmd_valid_i || pf_present;
    assign mem_is_pf_o = pf_present;
    assign mem_addr_o  = dmd_valid_i ? dmd_addr_i : (pf_addr_q & LINE_MASK);

    hwpf_credit_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_credit (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (pf_grant),
        .dec    (pf_rsp_valid_i),
        .count  (outstanding_o),
        .full   (cred_full)
    );

    // NOTE: every always_comb output gets its default first, so no path
    // through the case can infer a latch.
    always_comb begin
        state_d   = state_q;
        pf_addr_d = pf_addr_q;
        unique case (state_q)
            HWPF_IDLE: begin
                if (enable_i && (idle_cnt_q == IDLE_MAX) && !cred_full) begin
                    state_d = HWPF_POP;
                end
            end
            HWPF_POP: state_d = HWPF_CAPTURE;
            HWPF_CAPTURE: begin
                if (pf_valid_i) begin
                    pf_addr_d = pf_addr_i;
                    state_d   = HWPF_ISSUE;
                end else begin
                    state_d = HWPF_IDLE;
                end
            end
            HWPF_ISSUE: begin
                if (pf_grant) begin
                    state_d = HWPF_IDLE;
                end
            end
            default: state_d = HWPF_IDLE;
        endcase
        if (flush_i) begin
            state_d   = HWPF_IDLE;
            pf_addr_d = '0;
        end
    end

    // NOTE: the held prefetch address is a plain register, not a RAM, so it
    // takes the async reset like the rest of the control state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HWPF_IDLE;
            pf_addr_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pf_addr_q <= pf_addr_d;
            if (dmd_valid_i) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hwpf_issue_ctrl.sv
// Directed bench for hwpf_issue_ctrl: pop/issue latency, demand priority,
// empty FIFO, credit limits, enable drop, flush and mid-issue reset.
module tb_hwpf_issue_ctrl;

    localparam int unsigned ADDR_W = 40;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              enable_i;
    logic              flush_i;
    logic              dmd_valid_i;
    logic [ADDR_W-1:0] dmd_addr_i;
    logic              dmd_ready_o;
    logic              pf_read_o;
    logic              pf_valid_i;
    logic [ADDR_W-1:0] pf_addr_i;
    logic              mem_valid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_is_pf_o;
    logic              mem_ready_i;
    logic              pf_rsp_valid_i;
    logic [2:0]        outstanding_o;

    int total = 0;
    int bad   = 0;

    hwpf_issue_ctrl #(
        .ADDR_W          (ADDR_W),
        .LINE_BYTES      (64),
        .MAX_OUTSTANDING (4),
        .IDLE_CYCLES     (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .flush_i        (flush_i),
        .dmd_valid_i    (dmd_valid_i),
        .dmd_addr_i     (dmd_addr_i),
        .dmd_ready_o    (dmd_ready_o),
        .pf_read_o      (pf_read_o),
        .pf_valid_i     (pf_valid_i),
        .pf_addr_i      (pf_addr_i),
        .mem_valid_o    (mem_valid_o),
        .mem_addr_o     (mem_addr_o),
        .mem_is_pf_o    (mem_is_pf_o),
        .mem_ready_i    (mem_ready_i),
        .pf_rsp_valid_i (pf_rsp_valid_i),
        .outstanding_o  (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 1 later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_pop(input string tag, input int exp_n);
        int n = 0;
        while (pf_read_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(exp_n));
    endtask

    // Called while in POP: FIFO head becomes valid in CAPTURE, then ISSUE.
    task automatic fill(input logic [ADDR_W-1:0] a);
        tick();
        pf_valid_i = 1'b1;
        pf_addr_i  = a;
        tick();
        pf_valid_i = 1'b0;
        pf_addr_i  = '0;
        settle();
    endtask

    initial begin
        logic saw_pop;
        rst_ni = 1'b0; enable_i = 1'b1; flush_i = 1'b0;
        dmd_valid_i = 1'b0; dmd_addr_i = '0;
        pf_valid_i = 1'b0; pf_addr_i = '0;
        mem_ready_i = 1'b0; pf_rsp_valid_i = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_pf_read", pf_read_o, 0);
        check("rst_mem_valid", mem_valid_o, 0);
        check("rst_mem_is_pf", mem_is_pf_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        rst_ni = 1'b1;

        // Two demand-free cycles counted, then POP on the third edge
        wait_pop("first_pop_latency", 3);
        tick();
        check("pop_one_cycle", pf_read_o, 0);
        pf_valid_i = 1'b1; pf_addr_i = 40'h10_0047;
        pf_addr_i = 40'h1000_0047;
        tick();
        pf_valid_i = 1'b0;
        settle();
        check("issue_valid", mem_valid_o, 1);
        check("issue_is_pf", mem_is_pf_o, 1);
        check("issue_addr_aligned", mem_addr_o, 40'h1000_0040);
        check("issue_no_dmd_ready", dmd_ready_o, 0);
        tick();
        check("issue_held", mem_is_pf_o, 1);
        mem_ready_i = 1'b1;
        settle();
        check("dmd_ready_needs_valid", dmd_ready_o, 0);
        tick();
        mem_ready_i = 1'b0;
        check("grant_inc", outstanding_o, 1);
        check("grant_back_idle", mem_valid_o, 0);

        // Demand held over a pending prefetch for three cycles
        wait_pop("second_pop", 1);
        fill(40'h3000_0010);
        dmd_valid_i = 1'b1; dmd_addr_i = 40'h2000; mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("dmd_valid", mem_valid_o, 1);
            check("dmd_addr", mem_addr_o, 40'h2000);
            check("dmd_not_pf", mem_is_pf_o, 0);
            check("dmd_ready", dmd_ready_o, 1);
            tick();
            check("dmd_no_pf_inc", outstanding_o, 1);
        end
        dmd_valid_i = 1'b0; dmd_addr_i = '0;
        settle();
        check("pf_after_dmd", mem_is_pf_o, 1);
        check("pf_after_dmd_addr", mem_addr_o, 40'h3000_0000);
        tick();
        mem_ready_i = 1'b0;
        check("pf_after_dmd_inc", outstanding_o, 2);

        // Empty FIFO: pop, nothing captured, back to IDLE
        wait_pop("pop_after_dmd_idle", 2);
        tick();
        check("empty_capture_no_mem", mem_valid_o, 0);
        tick();
        check("empty_idle_no_mem", mem_valid_o, 0);
        check("empty_idle_no_pop", pf_read_o, 0);
        check("empty_no_inc", outstanding_o, 2);

        // Fill the credit window
        wait_pop("pop_3", 1);
        fill(40'h5000_0080);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        wait_pop("pop_4", 1);
        fill(40'h5000_00c0);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        check("credits_full", outstanding_o, 4);
        saw_pop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pf_read_o) saw_pop = 1'b1;
        end
        check("full_blocks_pop", saw_pop, 0);
        pf_rsp_valid_i = 1'b1;
        tick();
        check("rsp_dec", outstanding_o, 3);
        tick();
        pf_rsp_valid_i = 1'b0;
        check("rsp_dec_2", outstanding_o, 2);
        check("pop_resumes", pf_read_o, 1);

        // Grant and response together at 2
        fill(40'h6000_0000);
        mem_ready_i = 1'b1; pf_rsp_valid_i = 1'b1;
        tick();
        mem_ready_i = 1'b0; enable_i = 1'b0;
        check("inc_dec_same", outstanding_o, 2);
        tick();
        tick();
        check("drain_to_0", outstanding_o, 0);
        tick();
        pf_rsp_valid_i = 1'b0;
        check("no_underflow", outstanding_o, 0);
        check("disabled_no_pop", pf_read_o, 0);

        // Enable drops while ISSUE pending: the prefetch still completes
        enable_i = 1'b1;
        wait_pop("pop_enable", 1);
        fill(40'h7000_0123);
        enable_i = 1'b0;
        settle();
        check("disable_keeps_issue", mem_is_pf_o, 1);
        check("disable_issue_addr", mem_addr_o, 40'h7000_0100);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        saw_pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pf_read_o) saw_pop = 1'b1;
        end
        check("disable_stays_idle", saw_pop, 0);
        check("disable_issue_inc", outstanding_o, 1);

        // Flush during ISSUE with the port ready
        enable_i = 1'b1;
        wait_pop("pop_flush", 1);
        fill(40'h4000_00ff);
        flush_i = 1'b1; mem_ready_i = 1'b1;
        settle();
        check("flush_hides_pf", mem_is_pf_o, 0);
        check("flush_no_mem", mem_valid_o, 0);
        tick();
        flush_i = 1'b0; mem_ready_i = 1'b0;
        check("flush_keeps_count", outstanding_o, 1);
        check("flush_idle_no_pop", pf_read_o, 0);
        tick();
        check("flush_then_pop", pf_read_o, 1);

        // Reset asserted with a prefetch pending
        fill(40'h0800_0040);
        mem_ready_i = 1'b1;
        settle();
        check("pre_reset_issue", mem_is_pf_o, 1);
        rst_ni = 1'b0;
        settle();
        check("reset_drops_pf", mem_valid_o, 0);
        check("reset_clears_count", outstanding_o, 0);
        tick();
        check("reset_hold_no_pf", mem_is_pf_o, 0);
        mem_ready_i = 1'b0;
        rst_ni = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
